tl_rx_demux: RTL and testbench

Receive-side transaction-layer demultiplexer: accepts the TLP beat stream from the data-link layer, decodes the header beat, and steers each packet to the posted, non-posted or completion receive queue. It is the receive counterpart of the TX arbiter. It emits per-pool receive-credit pulses to the RX credit tracker and checks TLP length against the beat count. Unsupported or malformed packets are dropped or truncated and flagged.

---
 rtl/tl_rx_demux.sv | 262 ++++++++++++++++++++++++++
 tb/tb_tl_rx_demux.sv | 493 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_rx_demux.sv
// Receive-side TLP demultiplexer: decodes the header beat, steers each packet to the
// posted / non-posted / completion queue, emits receive-credit pulses and polices length.

package tl_pkg;
  typedef struct packed {
    logic [127:0] data;
    logic         sop;
    logic         eop;
  } tl_stream_t;

  typedef enum logic [1:0] {DEST_NONE, DEST_P, DEST_NP, DEST_CPL} dest_e;
endpackage

module tl_rx_demux
  import tl_pkg::*;
#(
  parameter int STREAM_W   = 128,
  parameter int PD_WIDTH   = 12,
  parameter int NPD_WIDTH  = 12,
  parameter int CPLD_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  tl_stream_t            tl_rx_i,
  input  logic                  tl_rx_valid_i,
  output logic                  tl_rx_ready_o,
  output tl_stream_t            pkt_posted_o,
  output tl_stream_t            pkt_np_o,
  output tl_stream_t            pkt_cpl_o,
  output logic                  pkt_posted_valid_o,
  output logic                  pkt_np_valid_o,
  output logic                  pkt_cpl_valid_o,
  input  logic                  pkt_posted_ready_i,
  input  logic                  pkt_np_ready_i,
  input  logic                  pkt_cpl_ready_i,
  output logic                  ph_rcv_v_o,
  output logic                  nph_rcv_v_o,
  output logic                  cplh_rcv_v_o,
  output logic                  pd_rcv_v_o,
  output logic [PD_WIDTH-1:0]   pd_rcv_dw_o,
  output logic                  npd_rcv_v_o,
  output logic [NPD_WIDTH-1:0]  npd_rcv_dw_o,
  output logic                  cpld_rcv_v_o,
  output logic [CPLD_WIDTH-1:0] cpld_rcv_dw_o,
  output logic                  malformed_o,
  output logic                  unsupported_o,
  output logic [7:0]            drop_cnt_o
);

  localparam int BEAT_DW = STREAM_W / 32;

  typedef enum logic [1:0] {S_IDLE, S_FWD, S_DROP} state_e;

  state_e     r_state, w_state_nxt;
  logic [8:0] r_cnt, w_cnt_nxt;
  tl_stream_t r_out;
  dest_e      r_dest;
  logic       r_out_valid;

  logic r_ph_v, r_nph_v, r_cplh_v, r_pd_v, r_npd_v, r_cpld_v, r_mal, r_uns;
  logic [PD_WIDTH-1:0]   r_pd_dw;
  logic [NPD_WIDTH-1:0]  r_npd_dw;
  logic [CPLD_WIDTH-1:0] r_cpld_dw;
  logic [7:0]            r_drop_cnt;

  // Header decode (only meaningful on a sop beat)
  logic [2:0]  w_fmt;
  logic [4:0]  w_type;
  logic        w_has_data;
  logic [9:0]  w_len;
  logic [10:0] w_len_dw;
  logic [8:0]  w_exp_beats;
  dest_e       w_class;

  assign w_fmt       = tl_rx_i.data[7:5];
  assign w_type      = tl_rx_i.data[4:0];
  assign w_has_data  = tl_rx_i.data[6];
  assign w_len       = {tl_rx_i.data[17:16], tl_rx_i.data[31:24]};
  assign w_len_dw    = (w_len == 10'd0) ? 11'd1024 : {1'b0, w_len};
  assign w_exp_beats = 9'((w_len_dw + 11'(BEAT_DW - 1)) / 11'(BEAT_DW));

  always_comb begin
    w_class = DEST_NONE;
    casez (w_type)
      5'b00000: begin
        if (w_fmt == 3'b010 || w_fmt == 3'b011)      w_class = DEST_P;
        else if (w_fmt == 3'b000 || w_fmt == 3'b001) w_class = DEST_NP;
      end
      5'b10???: w_class = DEST_P;
      5'b00010,
      5'b0010?: w_class = DEST_NP;
      5'b01010: w_class = DEST_CPL;
      default:  w_class = DEST_NONE;
    endcase
  end

  // Handshake: discarded beats never wait on a queue
  logic w_dest_ready, w_discard, w_acc;

  always_comb begin
    w_dest_ready = 1'b0;
    case (r_dest)
      DEST_P:   w_dest_ready = pkt_posted_ready_i;
      DEST_NP:  w_dest_ready = pkt_np_ready_i;
      DEST_CPL: w_dest_ready = pkt_cpl_ready_i;
      default:  w_dest_ready = 1'b0;
    endcase
  end

  assign w_discard     = (r_state == S_IDLE) && (!tl_rx_i.sop || w_class == DEST_NONE);
  assign tl_rx_ready_o = (r_state == S_DROP) || w_discard || !r_out_valid || w_dest_ready;
  assign w_acc         = tl_rx_valid_i && tl_rx_ready_o;

  logic       w_load, w_mal, w_uns, w_drop, w_credit;
  tl_stream_t w_load_beat;
  dest_e      w_load_dest;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_load_beat = tl_rx_i;
    w_load_dest = r_dest;
    w_mal       = 1'b0;
    w_uns       = 1'b0;
    w_drop      = 1'b0;
    w_credit    = 1'b0;
    if (w_acc) begin
      case (r_state)
        S_IDLE: begin
          if (!tl_rx_i.sop) begin
            w_mal  = 1'b1;
            w_drop = 1'b1;
            if (!tl_rx_i.eop) w_state_nxt = S_DROP;
          end else if (w_class == DEST_NONE) begin
            w_uns  = 1'b1;
            w_drop = 1'b1;
            if (!tl_rx_i.eop) w_state_nxt = S_DROP;
          end else begin
            w_load      = 1'b1;
            w_load_dest = w_class;
            w_credit    = 1'b1;
            if (w_has_data && !tl_rx_i.eop) begin
              w_state_nxt = S_FWD;
              w_cnt_nxt   = w_exp_beats;
            end else if (!w_has_data && !tl_rx_i.eop) begin
              w_load_beat.eop = 1'b1;
              w_mal           = 1'b1;
              w_state_nxt     = S_DROP;
            end else if (w_has_data && tl_rx_i.eop) begin
              w_mal = 1'b1;
            end
          end
        end
        S_FWD: begin
          w_load    = 1'b1;
          w_cnt_nxt = r_cnt - 9'd1;
          if (r_cnt == 9'd1) begin
            w_load_beat.eop = 1'b1;
            if (!tl_rx_i.eop) begin
              w_mal       = 1'b1;
              w_state_nxt = S_DROP;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else if (tl_rx_i.eop) begin
            w_mal       = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_DROP: begin
          if (tl_rx_i.eop) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  logic w_p_cr, w_np_cr, w_cpl_cr;
  assign w_p_cr   = w_credit && (w_load_dest == DEST_P);
  assign w_np_cr  = w_credit && (w_load_dest == DEST_NP);
  assign w_cpl_cr = w_credit && (w_load_dest == DEST_CPL);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Single output stage; the beat register is reset too so idle outputs read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_dest      <= DEST_NONE;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out       <= w_load_beat;
      r_dest      <= w_load_dest;
      r_out_valid <= 1'b1;
    end else if (w_dest_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ph_v     <= 1'b0;
      r_nph_v    <= 1'b0;
      r_cplh_v   <= 1'b0;
      r_pd_v     <= 1'b0;
      r_npd_v    <= 1'b0;
      r_cpld_v   <= 1'b0;
      r_pd_dw    <= '0;
      r_npd_dw   <= '0;
      r_cpld_dw  <= '0;
      r_mal      <= 1'b0;
      r_uns      <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_ph_v    <= w_p_cr;
      r_nph_v   <= w_np_cr;
      r_cplh_v  <= w_cpl_cr;
      r_pd_v    <= w_p_cr && w_has_data;
      r_npd_v   <= w_np_cr && w_has_data;
      r_cpld_v  <= w_cpl_cr && w_has_data;
      r_pd_dw   <= (w_p_cr && w_has_data)   ? PD_WIDTH'(w_len_dw)   : '0;
      r_npd_dw  <= (w_np_cr && w_has_data)  ? NPD_WIDTH'(w_len_dw)  : '0;
      r_cpld_dw <= (w_cpl_cr && w_has_data) ? CPLD_WIDTH'(w_len_dw) : '0;
      r_mal     <= w_mal;
      r_uns     <= w_uns;
      if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign pkt_posted_o       = r_out;
  assign pkt_np_o           = r_out;
  assign pkt_cpl_o          = r_out;
  assign pkt_posted_valid_o = r_out_valid && (r_dest == DEST_P);
  assign pkt_np_valid_o     = r_out_valid && (r_dest == DEST_NP);
  assign pkt_cpl_valid_o    = r_out_valid && (r_dest == DEST_CPL);
  assign ph_rcv_v_o         = r_ph_v;
  assign nph_rcv_v_o        = r_nph_v;
  assign cplh_rcv_v_o       = r_cplh_v;
  assign pd_rcv_v_o         = r_pd_v;
  assign npd_rcv_v_o        = r_npd_v;
  assign cpld_rcv_v_o       = r_cpld_v;
  assign pd_rcv_dw_o        = r_pd_dw;
  assign npd_rcv_dw_o       = r_npd_dw;
  assign cpld_rcv_dw_o      = r_cpld_dw;
  assign malformed_o        = r_mal;
  assign unsupported_o      = r_uns;
  assign drop_cnt_o         = r_drop_cnt;

endmodule

// File: tb/tb_tl_rx_demux.sv
// Self-checking bench for tl_rx_demux: packet-level reference model, output and
// pulse scoreboards, directed scenarios plus randomized traffic and backpressure.
`timescale 1ns/1ps
module tb_tl_rx_demux;
  import tl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tl_stream_t  tl_rx_i = '0;
  logic        tl_rx_valid_i = 1'b0;
  logic        tl_rx_ready_o;
  tl_stream_t  pkt_posted_o, pkt_np_o, pkt_cpl_o;
  logic        pkt_posted_valid_o, pkt_np_valid_o, pkt_cpl_valid_o;
  logic        pkt_posted_ready_i = 1'b1, pkt_np_ready_i = 1'b1, pkt_cpl_ready_i = 1'b1;
  logic        ph_rcv_v_o, nph_rcv_v_o, cplh_rcv_v_o;
  logic        pd_rcv_v_o, npd_rcv_v_o, cpld_rcv_v_o;
  logic [11:0] pd_rcv_dw_o, npd_rcv_dw_o, cpld_rcv_dw_o;
  logic        malformed_o, unsupported_o;
  logic [7:0]  drop_cnt_o;

  tl_rx_demux dut (
    .clk(clk), .rst_n(rst_n),
    .tl_rx_i(tl_rx_i), .tl_rx_valid_i(tl_rx_valid_i), .tl_rx_ready_o(tl_rx_ready_o),
    .pkt_posted_o(pkt_posted_o), .pkt_np_o(pkt_np_o), .pkt_cpl_o(pkt_cpl_o),
    .pkt_posted_valid_o(pkt_posted_valid_o), .pkt_np_valid_o(pkt_np_valid_o),
    .pkt_cpl_valid_o(pkt_cpl_valid_o),
    .pkt_posted_ready_i(pkt_posted_ready_i), .pkt_np_ready_i(pkt_np_ready_i),
    .pkt_cpl_ready_i(pkt_cpl_ready_i),
    .ph_rcv_v_o(ph_rcv_v_o), .nph_rcv_v_o(nph_rcv_v_o), .cplh_rcv_v_o(cplh_rcv_v_o),
    .pd_rcv_v_o(pd_rcv_v_o), .pd_rcv_dw_o(pd_rcv_dw_o),
    .npd_rcv_v_o(npd_rcv_v_o), .npd_rcv_dw_o(npd_rcv_dw_o),
    .cpld_rcv_v_o(cpld_rcv_v_o), .cpld_rcv_dw_o(cpld_rcv_dw_o),
    .malformed_o(malformed_o), .unsupported_o(unsupported_o), .drop_cnt_o(drop_cnt_o)
  );

  typedef struct {
    int         dest;
    tl_stream_t beat;
  } exp_beat_t;

  typedef struct packed {
    logic ph, nph, cplh, pd, npd, cpld;
    logic [11:0] pdw, npdw, cpldw;
    logic mal, uns;
  } pulse_t;

  exp_beat_t  exp_q[$];
  pulse_t     pulse_q[$];
  tl_stream_t pkt[$];
  int n_cmp = 0;
  int n_err = 0;
  int model_drop = 0;
  int rx_beats[3] = '{0, 0, 0};
  int ready_mode = 0;
  int stall_cnt = 0;
  bit mon_en = 1'b0;
  bit bp_seen = 1'b0;
  bit bubbles = 1'b0;

  // Queue readiness patterns: 0 all ready, 1 random, 2 cpl toggling, 3 none ready
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: begin pkt_posted_ready_i = 1; pkt_np_ready_i = 1; pkt_cpl_ready_i = 1; end
      1: begin
        pkt_posted_ready_i = ($urandom % 4) != 0;
        pkt_np_ready_i     = ($urandom % 4) != 0;
        pkt_cpl_ready_i    = ($urandom % 4) != 0;
      end
      2: begin pkt_posted_ready_i = 1; pkt_np_ready_i = 1; pkt_cpl_ready_i = !pkt_cpl_ready_i; end
      default: begin pkt_posted_ready_i = 0; pkt_np_ready_i = 0; pkt_cpl_ready_i = 0; end
    endcase
  end

  // Scoreboard: delivered beats and pulse cycles, both in order of occurrence
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      logic       v[3];
      logic       r[3];
      tl_stream_t b[3];
      pulse_t     obs;
      v = '{pkt_posted_valid_o, pkt_np_valid_o, pkt_cpl_valid_o};
      r = '{pkt_posted_ready_i, pkt_np_ready_i, pkt_cpl_ready_i};
      b = '{pkt_posted_o, pkt_np_o, pkt_cpl_o};
      n_cmp++;
      if (int'(v[0]) + int'(v[1]) + int'(v[2]) > 1) begin
        n_err++;
        $display("FAIL one_valid: valids=%b%b%b required at most one", v[0], v[1], v[2]);
      end
      for (int q = 0; q < 3; q++) begin
        if (v[q] && r[q]) begin
          n_cmp++;
          rx_beats[q]++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL out_beat: queue %0d delivered %h/%b%b, required nothing", q,
                     b[q].data, b[q].sop, b[q].eop);
          end else begin
            exp_beat_t e;
            e = exp_q.pop_front();
            if (e.dest != q || b[q] !== e.beat) begin
              n_err++;
              $display("FAIL out_beat: got q%0d %h/%b%b required q%0d %h/%b%b", q,
                       b[q].data, b[q].sop, b[q].eop, e.dest, e.beat.data, e.beat.sop, e.beat.eop);
            end
          end
        end
      end
      obs.ph = ph_rcv_v_o; obs.nph = nph_rcv_v_o; obs.cplh = cplh_rcv_v_o;
      obs.pd = pd_rcv_v_o; obs.npd = npd_rcv_v_o; obs.cpld = cpld_rcv_v_o;
      obs.pdw   = pd_rcv_v_o   ? pd_rcv_dw_o   : 12'd0;
      obs.npdw  = npd_rcv_v_o  ? npd_rcv_dw_o  : 12'd0;
      obs.cpldw = cpld_rcv_v_o ? cpld_rcv_dw_o : 12'd0;
      obs.mal = malformed_o; obs.uns = unsupported_o;
      if (obs != '0) begin
        n_cmp++;
        if (pulse_q.size() == 0) begin
          n_err++;
          $display("FAIL pulse: got %h required no pulse", obs);
        end else begin
          pulse_t e;
          e = pulse_q.pop_front();
          if (obs !== e) begin
            n_err++;
            $display("FAIL pulse: got %h required %h", obs, e);
          end
        end
      end
      if (tl_rx_valid_i && !tl_rx_ready_o) bp_seen = 1'b1;
    end
  end

  function automatic int classify(logic [2:0] f, logic [4:0] t);
    if (t == 5'd0) return (f == 3'b010 || f == 3'b011) ? 0 : (f == 3'b000 || f == 3'b001) ? 1 : -1;
    if (t >= 5'b10000 && t <= 5'b10111) return 0;
    if (t == 5'd2 || t == 5'd4 || t == 5'd5) return 1;
    if (t == 5'b01010) return 2;
    return -1;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic build_pkt(input logic [2:0] fmt, input logic [4:0] typ,
                           input logic [9:0] len, input int nd);
    tl_stream_t h;
    pkt.delete();
    h.data = rnd128();
    h.data[7:5] = fmt;
    h.data[4:0] = typ;
    h.data[17:16] = len[9:8];
    h.data[31:24] = len[7:0];
    h.sop = 1'b1;
    h.eop = (nd == 0);
    pkt.push_back(h);
    for (int i = 0; i < nd; i++) begin
      tl_stream_t d;
      d.data = rnd128();
      d.sop = 1'b0;
      d.eop = (i == nd - 1);
      pkt.push_back(d);
    end
  endtask

  // Packet-level expectation: forwarded beats = header + min(sent, expected) data beats
  task automatic model_pkt(input logic [2:0] fmt, input logic [4:0] typ,
                           input logic [9:0] len, input int nd);
    int cls, len_dw, e_beats, nf;
    pulse_t p;
    cls = classify(fmt, typ);
    p = '0;
    if (cls < 0) begin
      p.uns = 1'b1;
      pulse_q.push_back(p);
      if (model_drop < 255) model_drop++;
      return;
    end
    len_dw  = (len == 0) ? 1024 : int'(len);
    e_beats = fmt[1] ? (len_dw + 3) / 4 : 0;
    nf = 1 + ((nd < e_beats) ? nd : e_beats);
    for (int i = 0; i < nf; i++) begin
      exp_beat_t x;
      x.dest = cls;
      x.beat = pkt[i];
      if (i == nf - 1) x.beat.eop = 1'b1;
      exp_q.push_back(x);
    end
    case (cls)
      0: begin p.ph = 1; if (fmt[1]) begin p.pd = 1; p.pdw = 12'(len_dw); end end
      1: begin p.nph = 1; if (fmt[1]) begin p.npd = 1; p.npdw = 12'(len_dw); end end
      default: begin p.cplh = 1; if (fmt[1]) begin p.cpld = 1; p.cpldw = 12'(len_dw); end end
    endcase
    if (nd != e_beats && (nd == 0 || e_beats == 0)) begin
      p.mal = 1'b1;
      pulse_q.push_back(p);
    end else begin
      pulse_q.push_back(p);
      if (nd != e_beats) begin
        p = '0;
        p.mal = 1'b1;
        pulse_q.push_back(p);
      end
    end
  endtask

  task automatic garbage(input int k);
    pulse_t p;
    pkt.delete();
    for (int i = 0; i < k; i++) begin
      tl_stream_t d;
      d.data = rnd128();
      d.sop = 1'b0;
      d.eop = (i == k - 1);
      pkt.push_back(d);
    end
    p = '0;
    p.mal = 1'b1;
    pulse_q.push_back(p);
    if (model_drop < 255) model_drop++;
  endtask

  // Called and returns at posedge+1; ready is sampled on the preceding negedge
  task automatic send_beat(input tl_stream_t b);
    bit acc;
    int cyc;
    tl_rx_i = b;
    tl_rx_valid_i = 1'b1;
    cyc = 0;
    forever begin
      @(negedge clk);
      acc = tl_rx_ready_o;
      @(posedge clk);
      #1;
      if (acc) break;
      stall_cnt++;
      cyc++;
      if (cyc > 1000) begin
        n_cmp++;
        n_err++;
        $display("FAIL accept_timeout: beat not accepted in %0d cycles, required acceptance", cyc);
        break;
      end
    end
    tl_rx_valid_i = 1'b0;
  endtask

  task automatic drive_pkt();
    foreach (pkt[i]) begin
      if (bubbles && ($urandom % 4) == 0) begin
        @(posedge clk);
        #1;
      end
      send_beat(pkt[i]);
    end
  endtask

  task automatic send_pkt(input logic [2:0] fmt, input logic [4:0] typ,
                          input logic [9:0] len, input int nd);
    build_pkt(fmt, typ, len, nd);
    model_pkt(fmt, typ, len, nd);
    drive_pkt();
  endtask

  task automatic wait_drain(input string name);
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || pulse_q.size() != 0 ||
            pkt_posted_valid_o || pkt_np_valid_o || pkt_cpl_valid_o) && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0 || pulse_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: %0d beats and %0d pulses outstanding, required 0 and 0",
               name, exp_q.size(), pulse_q.size());
      exp_q.delete();
      pulse_q.delete();
    end
    n_cmp++;
    if (drop_cnt_o !== 8'(model_drop)) begin
      n_err++;
      $display("FAIL %s_drop_cnt: got %0d required %0d", name, drop_cnt_o, model_drop);
    end
  endtask

  task automatic check_reset_values(input string name);
    @(negedge clk);
    n_cmp++;
    if ({pkt_posted_valid_o, pkt_np_valid_o, pkt_cpl_valid_o, ph_rcv_v_o, nph_rcv_v_o,
         cplh_rcv_v_o, pd_rcv_v_o, npd_rcv_v_o, cpld_rcv_v_o, malformed_o, unsupported_o} !== '0) begin
      n_err++;
      $display("FAIL %s_flags: valids/pulses nonzero, required all 0", name);
    end
    n_cmp++;
    if (tl_rx_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL %s_ready: got %b required 1", name, tl_rx_ready_o);
    end
    n_cmp++;
    if (drop_cnt_o !== 8'd0 || pd_rcv_dw_o !== 12'd0 || npd_rcv_dw_o !== 12'd0 ||
        cpld_rcv_dw_o !== 12'd0 || pkt_posted_o !== '0 || pkt_np_o !== '0 || pkt_cpl_o !== '0) begin
      n_err++;
      $display("FAIL %s_counts: drop=%0d dw=%0d/%0d/%0d or beats nonzero, required all 0",
               name, drop_cnt_o, pd_rcv_dw_o, npd_rcv_dw_o, cpld_rcv_dw_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    check_reset_values("reset_asserted");
    rst_n = 1'b1;
    check_reset_values("reset_released");
    @(posedge clk);
    #1;
    mon_en = 1'b1;
  endtask

  task automatic test_posted_mwr();
    int base;
    ready_mode = 0;
    base = rx_beats[0];
    build_pkt(3'b011, 5'b00000, 10'd8, 2);
    model_pkt(3'b011, 5'b00000, 10'd8, 2);
    send_beat(pkt[0]);
    @(negedge clk);
    n_cmp++;
    if (!(pkt_posted_valid_o === 1'b1 && ph_rcv_v_o === 1'b1 && pd_rcv_v_o === 1'b1 &&
          pd_rcv_dw_o === 12'd8)) begin
      n_err++;
      $display("FAIL mwr_latency: valid=%b ph=%b pd=%b dw=%0d required 1 1 1 8",
               pkt_posted_valid_o, ph_rcv_v_o, pd_rcv_v_o, pd_rcv_dw_o);
    end
    @(posedge clk);
    #1;
    send_beat(pkt[1]);
    send_beat(pkt[2]);
    wait_drain("mwr");
    n_cmp++;
    if (rx_beats[0] - base != 3) begin
      n_err++;
      $display("FAIL mwr_beats: got %0d required 3", rx_beats[0] - base);
    end
  endtask

  task automatic test_np_mrd();
    int base;
    base = rx_beats[1];
    send_pkt(3'b000, 5'b00000, 10'd1, 0);
    wait_drain("mrd");
    n_cmp++;
    if (rx_beats[1] - base != 1) begin
      n_err++;
      $display("FAIL mrd_beats: got %0d required 1", rx_beats[1] - base);
    end
  endtask

  task automatic test_cpld_1024();
    int base;
    ready_mode = 2;
    bp_seen = 1'b0;
    base = rx_beats[2];
    send_pkt(3'b010, 5'b01010, 10'd0, 256);
    wait_drain("cpld1024");
    n_cmp++;
    if (rx_beats[2] - base != 257) begin
      n_err++;
      $display("FAIL cpld1024_beats: got %0d required 257", rx_beats[2] - base);
    end
    n_cmp++;
    if (!bp_seen) begin
      n_err++;
      $display("FAIL cpld1024_backpressure: ready never dropped, required at least once");
    end
    ready_mode = 0;
  endtask

  task automatic test_unsupported();
    ready_mode = 3;
    stall_cnt = 0;
    send_pkt(3'b011, 5'b11111, 10'd8, 3);
    wait_drain("unsupported");
    n_cmp++;
    if (stall_cnt != 0) begin
      n_err++;
      $display("FAIL unsupported_ready: %0d stall cycles, required 0", stall_cnt);
    end
    ready_mode = 0;
  endtask

  task automatic test_truncate();
    int base;
    ready_mode = 0;
    base = rx_beats[0];
    send_pkt(3'b010, 5'b00000, 10'd4, 3);
    send_pkt(3'b011, 5'b00000, 10'd4, 1);
    wait_drain("truncate");
    n_cmp++;
    if (rx_beats[0] - base != 4) begin
      n_err++;
      $display("FAIL truncate_beats: got %0d required 4", rx_beats[0] - base);
    end
  endtask

  task automatic test_random();
    logic [4:0] types[8];
    types = '{5'b00000, 5'b10011, 5'b00010, 5'b00100, 5'b00101, 5'b01010, 5'b11111, 5'b00000};
    ready_mode = 1;
    bubbles = 1'b1;
    for (int n = 0; n < 60; n++) begin
      if (($urandom % 10) == 0) begin
        garbage(1 + int'($urandom % 3));
        drive_pkt();
      end else begin
        logic [2:0] fmt;
        logic [4:0] typ;
        logic [9:0] len;
        int e_beats, nd;
        fmt = 3'($urandom % 8);
        typ = types[$urandom % 8];
        if (n % 8 == 7) typ = 5'($urandom);
        len = 10'(1 + $urandom % 40);
        e_beats = fmt[1] ? (int'(len) + 3) / 4 : 0;
        case ($urandom % 4)
          0, 1:    nd = e_beats;
          2:       nd = e_beats + 1 + int'($urandom % 2);
          default: nd = (e_beats > 0) ? int'($urandom % e_beats) : 0;
        endcase
        send_pkt(fmt, typ, len, nd);
      end
    end
    wait_drain("random");
    bubbles = 1'b0;
    ready_mode = 0;
  endtask

  task automatic test_saturate();
    for (int n = 0; n < 260; n++) send_pkt(3'b000, 5'b11111, 10'd1, 0);
    wait_drain("saturate");
    n_cmp++;
    if (drop_cnt_o !== 8'd255) begin
      n_err++;
      $display("FAIL saturate: got %0d required 255", drop_cnt_o);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    ready_mode = 0;
    mon_en = 1'b0;
    build_pkt(3'b011, 5'b00000, 10'd64, 16);
    for (int i = 0; i < 4; i++) send_beat(pkt[i]);
    rst_n = 1'b0;
    check_reset_values("reset_mid");
    rst_n = 1'b1;
    exp_q.delete();
    pulse_q.delete();
    model_drop = 0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    base = rx_beats[1];
    send_pkt(3'b001, 5'b00100, 10'd1, 0);
    wait_drain("after_reset");
    n_cmp++;
    if (rx_beats[1] - base != 1) begin
      n_err++;
      $display("FAIL after_reset_beats: got %0d required 1", rx_beats[1] - base);
    end
  endtask

  initial begin
    test_reset();
    test_posted_mwr();
    test_np_mrd();
    test_cpld_1024();
    test_unsupported();
    test_truncate();
    test_random();
    test_saturate();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
